instr_fetch: RTL and testbench

- Reader-side front end for the 1024x32 instruction ROM (ports clk/addr/instr, synchronous read, one-cycle latency).
- Generates the word-address stream on rom_addr and tags each returned word with its PC.
- Buffers returned words in a 2-entry queue and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/jump) with squash of stale in-flight reads.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_pkg;

  localparam int unsigned IF_ADDR_W = 10;
  localparam int unsigned IF_DATA_W = 32;
  localparam int unsigned FQ_DEPTH  = 2;
  localparam int unsigned FQ_CNT_W  = $clog2(FQ_DEPTH + 1);

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries between the ROM and decode.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                push_i,
  input  entry_t              push_entry_i,
  input  logic                pop_i,
  output logic [FQ_CNT_W-1:0] count_o,
  output entry_t              head_o
);

  localparam int unsigned PtrW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  entry_t              mem_q [FQ_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_d, wr_ptr_d;
  logic [FQ_CNT_W-1:0] count_q, count_d;
  logic                do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FQ_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Popping an empty queue is ignored so decode may hold ready high freely.
  assign do_pop = pop_i & (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + FQ_CNT_W'(push_i) - FQ_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: issues ROM word reads, tags returned words with their PC and
// queues them for decode behind a valid/ready handshake, with redirect squash.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IF_ADDR_W,
  parameter int unsigned       DATA_W   = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_instr,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [FQ_CNT_W-1:0] q_count;
  logic [FQ_CNT_W:0]   credit;
  logic                pop, push, issue;
  entry_t              head, push_entry;

  assign pop = if_valid & if_ready;

  // Queued plus in-flight words must leave room for the word about to be issued.
  assign credit = {1'b0, q_count} + (FQ_CNT_W + 1)'(inflight_q);
  assign issue  = fetch_en & ~redirect_valid &
                  (credit < ((FQ_CNT_W + 1)'(FQ_DEPTH) + (FQ_CNT_W + 1)'(pop)));

  // Data arriving in a redirect cycle belongs to the old stream and is dropped.
  assign push       = inflight_q & ~redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: rom_instr};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      inflight_pc_d = fetch_pc_q;
      inflight_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_queue #(
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (q_count),
    .head_o       (head)
  );

  assign rom_addr = fetch_pc_q;
  assign if_valid = (q_count != '0);
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model, scoreboard of expected (pc, instr) per stream,
// directed scenarios followed by randomized ready/enable/redirect traffic.
module tb_instr_fetch;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_instr;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instr;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  // Synchronous-read ROM, one cycle latency.
  logic [DW-1:0] rom_mem [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 32'hA000_0000 | 32'(i);
  always @(posedge clk) rom_instr <= rom_mem[rom_addr];

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a stream started at pc yields pc, pc+1, ... mod 2^AW, each with its ROM word.
  task automatic restart(input logic [AW-1:0] pc);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < (1 << AW); i++) begin
      e.pc    = pc + AW'(i);
      e.instr = 32'hA000_0000 | 32'(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: scoreboard on accepted entries and head stability under backpressure.
  logic          hold_prev = 1'b0;
  logic [AW-1:0] pc_prev;
  logic [DW-1:0] ins_prev;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold_valid", 32'(if_valid), 32'd1);
      check("hold_pc", 32'(if_pc), 32'(pc_prev));
      check("hold_instr", if_instr, ins_prev);
    end
    if (!rst && !redirect_valid && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: accepted pc %0d, expected no entry", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", 32'(if_pc), 32'(mon_e.pc));
        check("sb_instr", if_instr, mon_e.instr);
      end
    end
    hold_prev = !rst && !redirect_valid && if_valid && !if_ready;
    pc_prev   = if_pc;
    ins_prev  = if_instr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (!if_valid && n < max) begin
      cyc();
      n++;
    end
    check(name, 32'(if_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    restart(pc);
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] addr_mark;
    logic [AW-1:0] pc_tmp;
    int            n;

    rst            = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    restart('0);
    repeat (3) cyc();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);

    // Release: valid must rise exactly two cycles later, then stream gap-free.
    rst = 1'b0;
    cyc();
    check("lat_c1_valid", 32'(if_valid), 32'd0);
    cyc();
    check("lat_c2_valid", 32'(if_valid), 32'd1);
    check("first_pc", 32'(if_pc), 32'd0);
    check("first_instr", if_instr, 32'hA000_0000);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("stream_valid", 32'(if_valid), 32'd1);
    end

    // Backpressure for 5 cycles.
    if_ready = 1'b0;
    repeat (2) cyc();
    addr_mark = rom_addr;
    repeat (3) cyc();
    pc_tmp = if_pc + AW'(2);
    check("bp_valid", 32'(if_valid), 32'd1);
    check("bp_addr_hold", 32'(rom_addr), 32'(addr_mark));
    check("bp_addr_depth", 32'(rom_addr), 32'(pc_tmp));
    if_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_resume_valid", 32'(if_valid), 32'd1);
    end

    // Redirect while streaming.
    do_redirect(AW'(300));
    check("redir_valid_off", 32'(if_valid), 32'd0);
    wait_valid(4, "redir_timeout");
    check("redir_pc", 32'(if_pc), 32'd300);
    check("redir_instr", if_instr, 32'hA000_012C);
    repeat (5) cyc();

    // Wrap around the top of the address space.
    do_redirect(AW'(1022));
    wait_valid(4, "wrap_timeout");
    for (int i = 0; i < 4; i++) begin
      pc_tmp = AW'(1022) + AW'(i);
      check("wrap_valid", 32'(if_valid), 32'd1);
      check("wrap_pc", 32'(if_pc), 32'(pc_tmp));
      cyc();
    end

    // fetch_en low for 4 cycles drains at most 2 entries.
    fetch_en = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n += int'(if_valid);
    end
    check("en_off_max2", 32'(n <= 2), 32'd1);
    check("en_off_drained", 32'(if_valid), 32'd0);
    fetch_en = 1'b1;
    wait_valid(4, "en_resume_timeout");
    repeat (10) cyc();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      fetch_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) begin
        do_redirect(AW'($urandom_range(0, (1 << AW) - 1)));
      end else begin
        cyc();
      end
    end

    // Reset mid-stream with the queue full.
    fetch_en = 1'b1;
    if_ready = 1'b0;
    repeat (4) cyc();
    check("full_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    restart('0);
    cyc();
    rst      = 1'b0;
    if_ready = 1'b1;
    check("mrst_if_valid", 32'(if_valid), 32'd0);
    check("mrst_if_pc", 32'(if_pc), 32'd0);
    check("mrst_if_instr", if_instr, 32'd0);
    check("mrst_rom_addr", 32'(rom_addr), 32'd0);
    wait_valid(4, "mrst_timeout");
    check("mrst_first_pc", 32'(if_pc), 32'd0);
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
